// File: rtl/ahb_bus_arbiter_if.sv
// Bundles the requester handshakes and the AHB-Lite bus of the two-master arbiter.
// Modport master is the arbiter, which drives the AHB bus; slave is everything around it.
interface ahb_bus_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              req0;
    logic [ADDR_W-1:0] addr0;
    logic              req1;
    logic              we1;
    logic [ADDR_W-1:0] addr1;
    logic [2:0]        size1;
    logic [DATA_W-1:0] wdata1;
    logic              gnt0;
    logic              gnt1;
    logic              done0;
    logic              done1;
    logic [DATA_W-1:0] rdata;
    logic              err;
    logic [1:0]        htrans;
    logic [ADDR_W-1:0] haddr;
    logic              hwrite;
    logic [2:0]        hsize;
    logic [3:0]        hprot;
    logic [DATA_W-1:0] hwdata;
    logic              hready;
    logic              hresp;
    logic [DATA_W-1:0] hrdata;

    modport master (
        input  req0, addr0, req1, we1, addr1, size1, wdata1, hready, hresp, hrdata,
        output gnt0, gnt1, done0, done1, rdata, err,
        output htrans, haddr, hwrite, hsize, hprot, hwdata
    );

    modport slave (
        output req0, addr0, req1, we1, addr1, size1, wdata1, hready, hresp, hrdata,
        input  gnt0, gnt1, done0, done1, rdata, err,
        input  htrans, haddr, hwrite, hsize, hprot, hwdata
    );
endinterface

// File: rtl/ahb_bus_arbiter.sv
// Round-robin two-master AHB-Lite arbiter running one non-pipelined transfer at a time.
// Define AHB_ARB_TIMEOUT_EN to abort data phases that wait TIMEOUT_CYCLES without hready.
module ahb_bus_arbiter #(
    parameter int ADDR_W         = 32,
    parameter int DATA_W         = 32,
    parameter int TIMEOUT_CYCLES = 16
) (
    input logic             clk,
    input logic             reset,
    ahb_bus_arbiter_if.master bus
);
    typedef enum logic [1:0] {ST_IDLE, ST_ADDR, ST_DATA} state_t;

    state_t            state_q, state_d;
    logic              last_gnt_q, last_gnt_d;
    logic              gnt0_q, gnt0_d, gnt1_q, gnt1_d;
    logic              done0_q, done0_d, done1_q, done1_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic              err_q, err_d;
    logic [1:0]        htrans_q, htrans_d;
    logic [ADDR_W-1:0] haddr_q, haddr_d;
    logic              hwrite_q, hwrite_d;
    logic [2:0]        hsize_q, hsize_d;
    logic [3:0]        hprot_q, hprot_d;
    logic [DATA_W-1:0] hwdata_q, hwdata_d;

    logic elig0, elig1, grant_any, pick1, abort_hit;

    if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
        $error("TIMEOUT_CYCLES must be at least 1");
    end

    // A requester is ignored in its own done cycle so a held req is not re-granted.
    assign elig0     = bus.req0 && !done0_q;
    assign elig1     = bus.req1 && !done1_q;
    assign grant_any = elig0 || elig1;
    assign pick1     = elig1 && (!elig0 || !last_gnt_q);

`ifdef AHB_ARB_TIMEOUT_EN
    localparam int WAIT_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [WAIT_W-1:0] wait_q, wait_d;

    assign abort_hit = (state_q == ST_DATA) && !bus.hready &&
                       (wait_q == WAIT_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wait_q <= '0;
        end else begin
            wait_q <= wait_d;
        end
    end

    always_comb begin
        wait_d = wait_q;
        if (state_q == ST_ADDR) begin
            wait_d = '0;
        end else if (state_q == ST_DATA && !bus.hready) begin
            wait_d = wait_q + 1'b1;
        end
    end
`else
    assign abort_hit = 1'b0;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= ST_IDLE;
            last_gnt_q <= 1'b1;
            gnt0_q     <= 1'b0;
            gnt1_q     <= 1'b0;
            done0_q    <= 1'b0;
            done1_q    <= 1'b0;
            rdata_q    <= '0;
            err_q      <= 1'b0;
            htrans_q   <= 2'b00;
            haddr_q    <= '0;
            hwrite_q   <= 1'b0;
            hsize_q    <= 3'b000;
            hprot_q    <= 4'b0000;
            hwdata_q   <= '0;
        end else begin
            state_q    <= state_d;
            last_gnt_q <= last_gnt_d;
            gnt0_q     <= gnt0_d;
            gnt1_q     <= gnt1_d;
            done0_q    <= done0_d;
            done1_q    <= done1_d;
            rdata_q    <= rdata_d;
            err_q      <= err_d;
            htrans_q   <= htrans_d;
            haddr_q    <= haddr_d;
            hwrite_q   <= hwrite_d;
            hsize_q    <= hsize_d;
            hprot_q    <= hprot_d;
            hwdata_q   <= hwdata_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (grant_any) state_d = ST_ADDR;
            ST_ADDR: state_d = ST_DATA;
            ST_DATA: if (bus.hready || abort_hit) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Registered outputs: every field holds unless the current state updates it.
    always_comb begin
        last_gnt_d = last_gnt_q;
        gnt0_d     = gnt0_q;
        gnt1_d     = gnt1_q;
        done0_d    = 1'b0;
        done1_d    = 1'b0;
        rdata_d    = rdata_q;
        err_d      = err_q;
        htrans_d   = htrans_q;
        haddr_d    = haddr_q;
        hwrite_d   = hwrite_q;
        hsize_d    = hsize_q;
        hprot_d    = hprot_q;
        hwdata_d   = hwdata_q;
        case (state_q)
            ST_IDLE: begin
                if (grant_any) begin
                    last_gnt_d = pick1;
                    gnt0_d     = !pick1;
                    gnt1_d     = pick1;
                    htrans_d   = 2'b10;
                    haddr_d    = pick1 ? bus.addr1 : bus.addr0;
                    hwrite_d   = pick1 && bus.we1;
                    hsize_d    = pick1 ? bus.size1 : 3'b010;
                    hprot_d    = pick1 ? 4'b0011 : 4'b0010;
                    hwdata_d   = pick1 ? bus.wdata1 : '0;
                end
            end
            ST_ADDR: begin
                htrans_d = 2'b00;
            end
            ST_DATA: begin
                if (bus.hready) begin
                    done0_d = gnt0_q;
                    done1_d = gnt1_q;
                    rdata_d = hwrite_q ? '0 : bus.hrdata;
                    err_d   = bus.hresp;
                    gnt0_d  = 1'b0;
                    gnt1_d  = 1'b0;
                end else if (abort_hit) begin
                    done0_d = gnt0_q;
                    done1_d = gnt1_q;
                    rdata_d = '0;
                    err_d   = 1'b1;
                    gnt0_d  = 1'b0;
                    gnt1_d  = 1'b0;
                end
            end
            default: begin
                gnt0_d = 1'b0;
                gnt1_d = 1'b0;
            end
        endcase
    end

    assign bus.gnt0   = gnt0_q;
    assign bus.gnt1   = gnt1_q;
    assign bus.done0  = done0_q;
    assign bus.done1  = done1_q;
    assign bus.rdata  = rdata_q;
    assign bus.err    = err_q;
    assign bus.htrans = htrans_q;
    assign bus.haddr  = haddr_q;
    assign bus.hwrite = hwrite_q;
    assign bus.hsize  = hsize_q;
    assign bus.hprot  = hprot_q;
    assign bus.hwdata = hwdata_q;
endmodule

// File: tb/tb_ahb_bus_arbiter.sv
// Directed bench for ahb_bus_arbiter with a transfer-level reference model checked every cycle.
module tb_ahb_bus_arbiter;
    localparam int TO = 16;
`ifdef AHB_ARB_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    logic clk;
    logic reset;
    int   checks = 0;
    int   errors = 0;

    ahb_bus_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();

    ahb_bus_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT_CYCLES(TO)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, req, $time);
        end
    endtask

    // Reference model: one transfer record; age 1 = address phase, age >= 2 = data phase.
    bit          m_active;
    int          m_port;
    int          m_age;
    int          m_waits;
    int          m_last;
    logic [31:0] m_addr, m_wdata;
    bit          m_we;
    logic [2:0]  m_size;
    bit          e_done0, e_done1, e_err;
    logic [31:0] e_rdata;

    task automatic model_reset();
        m_active = 0; m_port = 0; m_age = 0; m_waits = 0; m_last = 1;
        m_addr = '0; m_wdata = '0; m_we = 0; m_size = '0;
        e_done0 = 0; e_done1 = 0; e_err = 0; e_rdata = '0;
    endtask

    task automatic model_finish(input bit abort);
        if (m_port == 0) e_done0 = 1; else e_done1 = 1;
        e_rdata  = (abort || m_we) ? 32'h0 : bus.hrdata;
        e_err    = abort ? 1'b1 : bus.hresp;
        m_active = 0;
    endtask

    task automatic model_step();
        bit pd0, pd1, w0, w1;
        int p;
        pd0 = e_done0; pd1 = e_done1;
        e_done0 = 0; e_done1 = 0;
        if (m_active) begin
            if (m_age >= 2) begin
                if (bus.hready) model_finish(1'b0);
                else begin
                    m_waits++;
                    if (TO_EN && m_waits == TO) model_finish(1'b1);
                end
            end
            if (m_active) m_age++;
        end else begin
            w0 = bus.req0 && !pd0;
            w1 = bus.req1 && !pd1;
            if (w0 || w1) begin
                p = (w0 && w1) ? 1 - m_last : (w1 ? 1 : 0);
                m_last = p; m_port = p; m_active = 1; m_age = 1; m_waits = 0;
                m_addr  = p ? bus.addr1 : bus.addr0;
                m_we    = p ? bus.we1 : 1'b0;
                m_size  = p ? bus.size1 : 3'b010;
                m_wdata = p ? bus.wdata1 : 32'h0;
            end
        end
    endtask

    always begin
        @(posedge clk);
        if (!reset) model_reset(); else model_step();
        #1;
        chk("m_gnt0",   32'(bus.gnt0),   32'(m_active && m_port == 0));
        chk("m_gnt1",   32'(bus.gnt1),   32'(m_active && m_port == 1));
        chk("m_done0",  32'(bus.done0),  32'(e_done0));
        chk("m_done1",  32'(bus.done1),  32'(e_done1));
        chk("m_htrans", 32'(bus.htrans), (m_active && m_age == 1) ? 32'd2 : 32'd0);
        chk("m_rdata",  bus.rdata,       e_rdata);
        chk("m_err",    32'(bus.err),    32'(e_err));
        if (m_active) begin
            chk("m_haddr",  bus.haddr,       m_addr);
            chk("m_hwrite", 32'(bus.hwrite), 32'(m_we));
            chk("m_hsize",  32'(bus.hsize),  32'(m_size));
            chk("m_hprot",  32'(bus.hprot),  m_port ? 32'h3 : 32'h2);
            if (m_we) chk("m_hwdata", bus.hwdata, m_wdata);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic all_zero(input string tag);
        chk({tag, "_gnt0"},   32'(bus.gnt0),   0);
        chk({tag, "_gnt1"},   32'(bus.gnt1),   0);
        chk({tag, "_done0"},  32'(bus.done0),  0);
        chk({tag, "_done1"},  32'(bus.done1),  0);
        chk({tag, "_htrans"}, 32'(bus.htrans), 0);
        chk({tag, "_haddr"},  bus.haddr,       0);
        chk({tag, "_hprot"},  32'(bus.hprot),  0);
        chk({tag, "_hwdata"}, bus.hwdata,      0);
        chk({tag, "_rdata"},  bus.rdata,       0);
        chk({tag, "_err"},    32'(bus.err),    0);
    endtask

    initial begin
        reset = 1'b1;
        bus.req0 = 0; bus.addr0 = '0; bus.req1 = 0; bus.we1 = 0; bus.addr1 = '0;
        bus.size1 = '0; bus.wdata1 = '0; bus.hready = 1; bus.hresp = 0; bus.hrdata = '0;
        #1 reset = 1'b0;
        bus.req0 = 1; bus.req1 = 1;
        repeat (3) tick();
        all_zero("rst");
        $display("txn reset held with both requests: outputs idle");

        // Both held from reset: port 0 first, then strict alternation every 3 cycles.
        @(negedge clk) reset = 1'b1;
        for (int c = 1; c <= 12; c++) begin
            tick();
            if (c == 1) begin
                chk("rr_first_gnt0", 32'(bus.gnt0), 1);
                chk("rr_first_gnt1", 32'(bus.gnt1), 0);
            end
            chk("rr_done0", 32'(bus.done0), 32'(c % 6 == 3));
            chk("rr_done1", 32'(bus.done1), 32'(c % 6 == 0));
            if (bus.done0 || bus.done1) $display("txn rr cycle %0d done0=%0b done1=%0b", c, bus.done0, bus.done1);
        end
        @(negedge clk) begin bus.req0 = 0; bus.req1 = 0; end
        repeat (2) tick();

        // Single ifetch read without wait states.
        @(negedge clk) begin bus.req0 = 1; bus.addr0 = 32'h10; bus.hrdata = 32'h0050_0093; end
        tick();
        chk("rd_htrans", 32'(bus.htrans), 32'h2);
        chk("rd_haddr",  bus.haddr,       32'h10);
        chk("rd_hwrite", 32'(bus.hwrite), 0);
        chk("rd_hsize",  32'(bus.hsize),  32'h2);
        chk("rd_hprot",  32'(bus.hprot),  32'h2);
        tick();
        chk("rd_htrans_data", 32'(bus.htrans), 0);
        tick();
        chk("rd_done0", 32'(bus.done0), 1);
        chk("rd_rdata", bus.rdata,       32'h0050_0093);
        chk("rd_err",   32'(bus.err),    0);
        $display("txn ifetch read addr=%h rdata=%h err=%0b", 32'h10, bus.rdata, bus.err);
        @(negedge clk) bus.req0 = 0;
        tick();
        chk("rd_after_gnt0", 32'(bus.gnt0), 0);

        // Byte write with three wait states.
        @(negedge clk) begin
            bus.req1 = 1; bus.we1 = 1; bus.addr1 = 32'h2000_0004; bus.size1 = 3'b000;
            bus.wdata1 = 32'hA5; bus.hrdata = 32'hDEAD_BEEF;
        end
        tick();
        chk("wr_htrans", 32'(bus.htrans), 32'h2);
        chk("wr_hwrite", 32'(bus.hwrite), 1);
        chk("wr_hsize",  32'(bus.hsize),  0);
        chk("wr_hprot",  32'(bus.hprot),  32'h3);
        @(negedge clk) bus.hready = 0;
        for (int c = 2; c <= 5; c++) begin
            tick();
            chk("wr_data_htrans", 32'(bus.htrans), 0);
            chk("wr_data_hwdata", bus.hwdata,      32'hA5);
            chk("wr_data_done1",  32'(bus.done1),  0);
        end
        @(negedge clk) bus.hready = 1;
        tick();
        chk("wr_done1", 32'(bus.done1), 1);
        chk("wr_rdata", bus.rdata,       0);
        chk("wr_err",   32'(bus.err),    0);
        $display("txn write addr=%h wdata=%h done1=%0b", 32'h2000_0004, 32'hA5, bus.done1);
        @(negedge clk) begin bus.req1 = 0; bus.we1 = 0; end
        tick();

        // hresp during a wait state must be ignored.
        @(negedge clk) begin
            bus.req1 = 1; bus.addr1 = 32'h3000_0000; bus.size1 = 3'b010; bus.hrdata = 32'h1234;
        end
        tick();
        @(negedge clk) begin bus.hready = 0; bus.hresp = 1; end
        tick();
        tick();
        chk("ign_done1", 32'(bus.done1), 0);
        @(negedge clk) begin bus.hready = 1; bus.hresp = 0; bus.hrdata = 32'h5678; end
        tick();
        chk("ign_done1_pulse", 32'(bus.done1), 1);
        chk("ign_err",         32'(bus.err),   0);
        chk("ign_rdata",       bus.rdata,      32'h5678);
        $display("txn read with ignored wait-state hresp rdata=%h err=%0b", bus.rdata, bus.err);
        @(negedge clk) bus.req1 = 0;
        tick();

        // Error response on the completing cycle.
        @(negedge clk) begin
            bus.req1 = 1; bus.addr1 = 32'h3000_0008; bus.hresp = 1; bus.hrdata = 32'h9999;
        end
        repeat (3) tick();
        chk("er_done1", 32'(bus.done1), 1);
        chk("er_err",   32'(bus.err),   1);
        chk("er_rdata", bus.rdata,      32'h9999);
        $display("txn read error err=%0b", bus.err);
        @(negedge clk) begin bus.req1 = 0; bus.hresp = 0; end
        tick();
        tick();
        chk("er_err_hold", 32'(bus.err), 1);

        // Asynchronous reset in the data phase abandons the transfer.
        @(negedge clk) begin bus.req1 = 1; bus.addr1 = 32'h3000_000C; bus.hready = 0; end
        tick();
        tick();
        #1 reset = 1'b0;
        #1;
        all_zero("arst");
        bus.req1 = 0;
        tick();
        @(negedge clk) begin reset = 1'b1; bus.hready = 1; end
        for (int c = 0; c < 4; c++) begin
            tick();
            chk("arst_no_done1", 32'(bus.done1), 0);
        end
        $display("txn async reset mid-data: transfer abandoned");

`ifdef AHB_ARB_TIMEOUT_EN
        @(negedge clk) begin bus.req1 = 1; bus.we1 = 0; bus.addr1 = 32'h40; bus.hready = 0; end
        for (int c = 1; c <= TO + 2; c++) begin
            tick();
            chk("to_done1", 32'(bus.done1), 32'(c == TO + 2));
        end
        chk("to_err",   32'(bus.err), 1);
        chk("to_rdata", bus.rdata,    0);
        $display("txn timeout abort err=%0b", bus.err);
        @(negedge clk) begin bus.req1 = 0; bus.hready = 1; end
        tick();
        chk("to_idle_gnt1", 32'(bus.gnt1), 0);
`endif

        repeat (2) tick();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
